demux14_reg: RTL and testbench
==============================

Name: demux14_reg

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake on the input and on every output lane. It is the inverse of the team's 4:1 mux path: one input stream is distributed onto lanes Y0..Y3.
- Lane selection has two modes:
  - explicit: the S input chooses the lane;
  - auto: an internal round-robin pointer chooses the lane, so the block acts as a 4-slot TDM deframer.
- Each lane holds one word until its consumer takes it.

Parameters:
- WIDTH, 1, data width of D and of each Y lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- S  input  2  lane select in explicit mode; ignored when auto_mode=1.
- auto_mode  input  1  1 = round-robin pointer selects the lane; 0 = S selects the lane.
- D  input  WIDTH  input data word.
- D_valid  input  1  D holds a valid word.
- D_ready  output  1  block can accept D this cycle.
- Y0, Y1, Y2, Y3  output  WIDTH each  lane data registers.
- Y_valid  output  4  bit i set = lane i holds an unconsumed word.
- Y_ready  input  4  bit i = lane i consumer accepts this cycle.
- ptr  output  2  current round-robin pointer.
- frame_done  output  1  one-cycle pulse after a full 4-word frame in auto mode.

Behaviour:
- Reset (rst=1 at a clk edge; dominates all other activity, including mid-transfer):
  - Y0..Y3 = 0, Y_valid = 4'b0000, ptr = 0, frame_done = 0.
  - Any word in flight is discarded.
- Target lane: T = auto_mode ? ptr : S. T is evaluated combinationally each cycle.
- D_ready is combinational: D_ready = !Y_valid[T] | Y_ready[T]. It does not depend on D_valid.
- Accept: occurs when D_valid & D_ready.
  - On the next edge, Y_T <= D and Y_valid[T] <= 1.
  - Latency is 1 cycle from accept to Y_valid.
- Drain:
  - When Y_valid[i] & Y_ready[i] and lane i is not loaded that cycle, Y_valid[i] <= 0.
  - The Y_i data register keeps its last value after drain; it is not cleared.
- Simultaneous drain and load on the same lane: the load wins. Y_valid[i] stays 1 and Y_i takes the new D, giving full throughput of 1 word/cycle per lane.
- Non-target lanes drain independently in the same cycle.
- Lane i holds data stable while Y_valid[i] & !Y_ready[i]. Its data and valid bit change only on drain or on load.
- Pointer:
  - Advances only on an accept while auto_mode=1. Sequence is 0→1→2→3→0, wrapping with 2-bit modular arithmetic.
  - Holds its value while auto_mode=0. Toggling auto_mode does not reset ptr; only rst clears it.
- frame_done:
  - Registered. Asserted for exactly one cycle on the edge where an auto-mode accept into lane 3 occurs, i.e. frame_done is high in the cycle ptr returns to 0.
  - Explicit-mode accepts into lane 3 never assert frame_done.
- Stall: if lane T is full and Y_ready[T]=0, D_ready=0 and the pointer does not advance. Other lanes keep draining.
- D_valid=0: no state change except drains. The block does not check S or D when D_valid=0.
- Mode change with a word pending on the input: the new T applies in the same cycle. No buffering exists outside the four lane registers.

Test Plan:
- Reset and explicit routing:
  - Stimulus: WIDTH=1, assert rst for 2 cycles; check all outputs are 0. Then auto_mode=0, Y_ready=4'b0000, D_valid=1, D=1 with S=0; next D=0, S=1; next D=1, S=2; next D=1, S=3.
  - Required: Y_valid progresses 0001, 0011, 0111, 1111 one cycle after each accept; Y0..Y3 = 1,0,1,1; D_ready=0 afterwards for any S.
- Back-pressure and hold:
  - Stimulus: with lane 2 full (Y2=1) and Y_ready[2]=0, present S=2, D=0 for 5 cycles; then raise Y_ready[2].
  - Required: D_ready=0 and Y2=1 for all 5 cycles. D_ready=1 in the Y_ready cycle, and Y2=0 with Y_valid[2]=1 on the next edge (load wins).
- Auto-mode frame:
  - Stimulus: auto_mode=1, Y_ready=4'b1111, D_valid=1 continuously, D = 1,0,0,1,1.
  - Required: ptr goes 0,1,2,3,0,1. Y0=1, Y1=0, Y2=0, Y3=1, then Y0=1. frame_done is high in exactly the cycle after the 4th accept.
- Auto stall:
  - Stimulus: in auto mode, ptr=1, Y_valid[1]=1, Y_ready[1]=0, D_valid=1 for 3 cycles.
  - Required: ptr stays 1, D_ready=0, frame_done=0. Lane 0 drains via Y_ready[0]=1 while stalled.
- Mode toggle:
  - Stimulus: in auto mode, leave ptr=2; switch auto_mode=0 and send 2 words with S=0.
  - Required: ptr stays 2, both words land in Y0. Switching back to auto_mode=1, the next word lands in Y2.
- Reset mid-operation:
  - Stimulus: Y_valid=4'b1010, ptr=3, D_valid=1, D_ready=1; assert rst for one edge.
  - Required: on the next cycle Y_valid=0000, ptr=0, Y0..Y3=0, frame_done=0; the word presented during reset is not stored.

Source files
------------

// File: rtl/demux14_reg.sv
// Registered 1-to-4 demultiplexer: one input stream is steered onto four
// independently drained output lanes, by S or by an internal round-robin pointer.
module demux14_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       S,
    input  logic             auto_mode,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic             D_ready,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [3:0]       Y_valid,
    input  logic [3:0]       Y_ready,
    output logic [1:0]       ptr,
    output logic             frame_done
);

    // Handshake: a word moves on any edge where valid & ready are both high.
    // A producer holds valid and data until accepted. D_ready never looks at
    // D_valid, and lane i keeps Y_i stable while Y_valid[i] & !Y_ready[i].
    logic [WIDTH-1:0] lane_q [4];
    logic [3:0]       lane_valid_q;
    logic [1:0]       ptr_q;
    logic             frame_done_q;
    logic [1:0]       tgt;
    logic             accept;

    assign tgt     = auto_mode ? ptr_q : S;
    assign D_ready = !lane_valid_q[tgt] | Y_ready[tgt];
    assign accept  = D_valid & D_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
            lane_valid_q <= 4'b0000;
            ptr_q        <= 2'd0;
            frame_done_q <= 1'b0;
        end else begin
            // Auto-mode accept into lane 3 completes a frame; ptr wraps to 0.
            frame_done_q <= accept & auto_mode & (ptr_q == 2'd3);
            if (accept & auto_mode) begin
                ptr_q <= ptr_q + 2'd1;
            end
            for (int i = 0; i < 4; i++) begin
                // A load outranks a drain on the same lane.
                if (accept && (tgt == i[1:0])) begin
                    lane_q[i]       <= D;
                    lane_valid_q[i] <= 1'b1;
                end else if (lane_valid_q[i] & Y_ready[i]) begin
                    lane_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign Y0         = lane_q[0];
    assign Y1         = lane_q[1];
    assign Y2         = lane_q[2];
    assign Y3         = lane_q[3];
    assign Y_valid    = lane_valid_q;
    assign ptr        = ptr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux14_reg.sv
// Directed bench for demux14_reg (WIDTH=1): explicit routing, back-pressure,
// auto-mode framing, stall, mode toggling and reset in mid-operation.
module tb_demux14_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] S;
    logic       auto_mode;
    logic [0:0] D;
    logic       D_valid;
    logic       D_ready;
    logic [0:0] Y0, Y1, Y2, Y3;
    logic [3:0] Y_valid;
    logic [3:0] Y_ready;
    logic [1:0] ptr;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    demux14_reg #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .S(S), .auto_mode(auto_mode),
        .D(D), .D_valid(D_valid), .D_ready(D_ready),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
        .Y_valid(Y_valid), .Y_ready(Y_ready),
        .ptr(ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; S = 2'd0; auto_mode = 1'b0; D = 1'b0; D_valid = 1'b0; Y_ready = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        check("rst_y_valid", 32'(Y_valid), 32'h0);
        check("rst_ptr", 32'(ptr), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_lanes", 32'({Y3, Y2, Y1, Y0}), 32'h0);

        // Explicit routing into an empty block
        D_valid = 1'b1; D = 1'b1; S = 2'd0;
        #1 check("exp_ready0", 32'(D_ready), 32'h1);
        tick();
        check("exp_valid0", 32'(Y_valid), 32'b0001);
        D = 1'b0; S = 2'd1;
        tick();
        check("exp_valid1", 32'(Y_valid), 32'b0011);
        D = 1'b1; S = 2'd2;
        tick();
        check("exp_valid2", 32'(Y_valid), 32'b0111);
        D = 1'b1; S = 2'd3;
        tick();
        check("exp_valid3", 32'(Y_valid), 32'b1111);
        check("exp_lanes", 32'({Y3, Y2, Y1, Y0}), 32'b1101);
        check("exp_no_frame", 32'(frame_done), 32'h0);
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            #1 check("exp_full_ready", 32'(D_ready), 32'h0);
        end

        // Back-pressure on lane 2, then drain and load in the same cycle
        S = 2'd2; D = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1 check("bp_ready", 32'(D_ready), 32'h0);
            check("bp_hold_y2", 32'(Y2), 32'h1);
            tick();
        end
        Y_ready = 4'b0100;
        #1 check("bp_release_ready", 32'(D_ready), 32'h1);
        tick();
        check("bp_y2_new", 32'(Y2), 32'h0);
        check("bp_valid_kept", 32'(Y_valid), 32'b1111);

        // Auto-mode frame, D = 1,0,0,1,1 with all lanes draining
        auto_mode = 1'b1; Y_ready = 4'b1111; D = 1'b1;
        check("af_ptr_start", 32'(ptr), 32'h0);
        tick();
        check("af_ptr1", 32'(ptr), 32'h1);
        check("af_y0", 32'(Y0), 32'h1);
        check("af_valid1", 32'(Y_valid), 32'b0001);
        D = 1'b0;
        tick();
        check("af_ptr2", 32'(ptr), 32'h2);
        check("af_y1", 32'(Y1), 32'h0);
        check("af_valid2", 32'(Y_valid), 32'b0010);
        check("af_fd_mid", 32'(frame_done), 32'h0);
        D = 1'b0;
        tick();
        check("af_ptr3", 32'(ptr), 32'h3);
        check("af_y2", 32'(Y2), 32'h0);
        D = 1'b1;
        tick();
        check("af_ptr0", 32'(ptr), 32'h0);
        check("af_y3", 32'(Y3), 32'h1);
        check("af_frame_done", 32'(frame_done), 32'h1);
        D = 1'b1;
        tick();
        check("af_ptr_next", 32'(ptr), 32'h1);
        check("af_y0_again", 32'(Y0), 32'h1);
        check("af_fd_pulse", 32'(frame_done), 32'h0);

        // Fill lane 1 explicitly (ptr holds at 1), lane 0 stays full
        auto_mode = 1'b0; S = 2'd1; D = 1'b1; Y_ready = 4'b0000;
        tick();
        check("st_setup_valid", 32'(Y_valid), 32'b0011);
        check("st_setup_ptr", 32'(ptr), 32'h1);

        // Auto stall on lane 1 while lane 0 drains
        auto_mode = 1'b1; Y_ready = 4'b0001; D = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("st_ready", 32'(D_ready), 32'h0);
            tick();
            check("st_ptr", 32'(ptr), 32'h1);
            check("st_fd", 32'(frame_done), 32'h0);
            check("st_valid", 32'(Y_valid), 32'b0010);
            check("st_y1_hold", 32'(Y1), 32'h1);
        end

        // Release lane 1 so ptr moves to 2
        Y_ready = 4'b0010;
        tick();
        check("mt_ptr2", 32'(ptr), 32'h2);
        check("mt_y1", 32'(Y1), 32'h0);

        // Explicit words into lane 0 leave ptr at 2
        auto_mode = 1'b0; S = 2'd0; D = 1'b1; Y_ready = 4'b0001;
        tick();
        check("mt_w1_y0", 32'(Y0), 32'h1);
        check("mt_w1_valid", 32'(Y_valid), 32'b0011);
        D = 1'b0;
        tick();
        check("mt_w2_y0", 32'(Y0), 32'h0);
        check("mt_w2_valid", 32'(Y_valid), 32'b0011);
        check("mt_ptr_hold", 32'(ptr), 32'h2);
        check("mt_fd", 32'(frame_done), 32'h0);
        auto_mode = 1'b1; D = 1'b1; Y_ready = 4'b0000;
        tick();
        check("mt_auto_y2", 32'(Y2), 32'h1);
        check("mt_auto_valid", 32'(Y_valid), 32'b0111);
        check("mt_auto_ptr", 32'(ptr), 32'h3);

        // Set up Y_valid=1010, ptr=3 with an explicit load into lane 3
        auto_mode = 1'b0; S = 2'd3; D = 1'b0; Y_ready = 4'b0101;
        tick();
        check("rm_setup_valid", 32'(Y_valid), 32'b1010);
        check("rm_setup_ptr", 32'(ptr), 32'h3);
        check("rm_setup_fd", 32'(frame_done), 32'h0);

        // Reset while an auto-mode accept into lane 3 is being offered
        auto_mode = 1'b1; D = 1'b1; D_valid = 1'b1; Y_ready = 4'b1000;
        #1 check("rm_ready", 32'(D_ready), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0; D_valid = 1'b0; Y_ready = 4'b0000;
        check("rm_valid", 32'(Y_valid), 32'h0);
        check("rm_ptr", 32'(ptr), 32'h0);
        check("rm_lanes", 32'({Y3, Y2, Y1, Y0}), 32'h0);
        check("rm_fd", 32'(frame_done), 32'h0);
        tick();
        check("rm_idle_valid", 32'(Y_valid), 32'h0);
        check("rm_idle_fd", 32'(frame_done), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
